// File: rtl/celement_sync_receiver_if.sv
// Bundled-data SEND/ACK token input and valid/ready word output
// of the C-element pipeline receiver.
interface celement_sync_receiver_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 SENDIN;
    logic [WIDTH-1:0]     DATAIN;
    logic                 ACKOUT;
    logic [WIDTH-1:0]     DOUT;
    logic                 DOUT_VALID;
    logic                 DOUT_READY;
    logic [CNT_WIDTH-1:0] TOKENS;
    logic                 BUSY;

    modport master (
        output SENDIN,
        output DATAIN,
        output DOUT_READY,
        input  ACKOUT,
        input  DOUT,
        input  DOUT_VALID,
        input  TOKENS,
        input  BUSY
    );

    modport slave (
        input  SENDIN,
        input  DATAIN,
        input  DOUT_READY,
        output ACKOUT,
        output DOUT,
        output DOUT_VALID,
        output TOKENS,
        output BUSY
    );
endinterface

// File: rtl/celement_sync_receiver.sv
// Clocked sink of a self-timed C-element pipeline: synchronises SENDIN,
// acknowledges tokens 4-phase and queues the bundled data in a FIFO.
module celement_sync_receiver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    CP,
    input  logic                    RESET,
    celement_sync_receiver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] SETTLE   = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] WAIT_RTZ = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic [1:0]             state_q, state_d;
    logic                   ack_q, ack_d;
    logic [CNT_WIDTH-1:0]   tokens_q, tokens_d;
    logic [AW:0]            wptr_q, wptr_d;
    logic [AW:0]            rptr_q, rptr_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];

    logic req_s;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = (state_q == CAPTURE);
    assign pop   = !empty && bus.DOUT_READY;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.SENDIN};
        // fill_q marks when every synchroniser stage holds a real sample
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        state_d  = state_q;
        ack_d    = 1'b0;
        tokens_d = tokens_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        mem_d    = mem_q;
        case (state_q)
            SETTLE: begin
                if (fill_q[SYNC_STAGES-1] && !req_s) state_d = IDLE;
            end
            IDLE: begin
                if (req_s && !full) state_d = CAPTURE;
            end
            CAPTURE: begin
                ack_d   = 1'b1;
                state_d = WAIT_RTZ;
            end
            default: begin
                ack_d = req_s;
                if (!req_s) state_d = IDLE;
            end
        endcase
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = bus.DATAIN;
            wptr_d   = wptr_q + 1'b1;
            tokens_d = tokens_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge CP or posedge RESET) begin
        if (RESET) begin
            sync_q   <= '0;
            fill_q   <= '0;
            state_q  <= SETTLE;
            ack_q    <= 1'b0;
            tokens_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync_q   <= sync_d;
            fill_q   <= fill_d;
            state_q  <= state_d;
            ack_q    <= ack_d;
            tokens_q <= tokens_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.ACKOUT     = ack_q;
    assign bus.DOUT       = mem_q[rptr_q[AW-1:0]];
    assign bus.DOUT_VALID = !empty;
    assign bus.TOKENS     = tokens_q;
    assign bus.BUSY       = (state_q != IDLE);
endmodule
